// File: rtl/mux_5to1_if.sv
// Bus bundle for mux_5to1: five data words, select and load enable in;
// registered word, its complement and the out-of-range flag out.
interface mux_5to1_if #(
    parameter int SZE = 4
);
    logic           en;
    logic [SZE-1:0] in0;
    logic [SZE-1:0] in1;
    logic [SZE-1:0] in2;
    logic [SZE-1:0] in3;
    logic [SZE-1:0] in4;
    logic [2:0]     sel;
    logic [SZE-1:0] out;
    logic [SZE-1:0] outbar;
    logic           sel_err;

    modport master (
        output en, in0, in1, in2, in3, in4, sel,
        input  out, outbar, sel_err
    );

    modport slave (
        input  en, in0, in1, in2, in3, in4, sel,
        output out, outbar, sel_err
    );
endinterface

// File: rtl/mux_5to1.sv
// Registered 5:1 word selector with true/inverted outputs and out-of-range flag.
// Define MUX5_1_OOR_HOLD_EN to hold the word on an out-of-range select instead of loading zero.
module mux_5to1 #(
    parameter int SZE = 4
) (
    input  logic       clk,
    input  logic       rst,
    mux_5to1_if.slave  bus
);
    logic [SZE-1:0] out_q, out_d;
    logic           err_q, err_d;

    always_comb begin
        out_d = out_q;
        err_d = err_q;
        if (bus.en) begin
            err_d = 1'b0;
            case (bus.sel)
                3'd0:    out_d = bus.in0;
                3'd1:    out_d = bus.in1;
                3'd2:    out_d = bus.in2;
                3'd3:    out_d = bus.in3;
                3'd4:    out_d = bus.in4;
                default: begin
                    err_d = 1'b1;
`ifdef MUX5_1_OOR_HOLD_EN
                    out_d = out_q;
`else
                    out_d = '0;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            err_q <= 1'b0;
        end else begin
            out_q <= out_d;
            err_q <= err_d;
        end
    end

    // Complement is derived, so out ^ outbar is all ones even through reset.
    assign bus.out     = out_q;
    assign bus.outbar  = ~out_q;
    assign bus.sel_err = err_q;
endmodule

// File: tb/tb_mux_5to1.sv
// Bench for mux_5to1: directed test-plan sequence with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_mux_5to1;
    localparam int SZE = 4;

    logic clk = 1'b0;
    logic rst;
    logic [SZE-1:0] din [5];

    int checks   = 0;
    int failures = 0;

    mux_5to1_if #(.SZE(SZE)) bus ();

    mux_5to1 #(.SZE(SZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.in0 = din[0];
    assign bus.in1 = din[1];
    assign bus.in2 = din[2];
    assign bus.in3 = din[3];
    assign bus.in4 = din[4];

    always #5 clk = ~clk;

`ifdef MUX5_1_OOR_HOLD_EN
    localparam bit OOR_HOLD = 1'b1;
`else
    localparam bit OOR_HOLD = 1'b0;
`endif

    task automatic check(input string name, input logic [SZE-1:0] act, input logic [SZE-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the word the register must hold after each edge.
    logic [SZE-1:0] m_out;
    logic           m_err;
    bit             m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_out   = '0;
            m_err   = 1'b0;
            m_valid = 1'b1;
        end else if (bus.en) begin
            if (int'(bus.sel) < 5) begin
                m_out = din[bus.sel];
                m_err = 1'b0;
            end else begin
                m_out = OOR_HOLD ? m_out : '0;
                m_err = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("out", bus.out, m_out);
            check("outbar", bus.outbar, ~m_out);
            check("sel_err", {{(SZE-1){1'b0}}, bus.sel_err}, {{(SZE-1){1'b0}}, m_err});
            check("invariant", bus.out ^ bus.outbar, {SZE{1'b1}});
        end
    end

    // Drive one cycle of inputs, then land 2 time units after the capturing edge.
    task automatic cyc(input logic r, input logic e, input logic [2:0] s);
        rst     = r;
        bus.en  = e;
        bus.sel = s;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [SZE-1:0] o, input logic [SZE-1:0] ob, input logic er);
        check({name, ".out"}, bus.out, o);
        check({name, ".outbar"}, bus.outbar, ob);
        check({name, ".err"}, {{(SZE-1){1'b0}}, bus.sel_err}, {{(SZE-1){1'b0}}, er});
    endtask

    initial begin
        din[0] = 4'hE; din[1] = 4'hF; din[2] = 4'h0; din[3] = 4'h1; din[4] = 4'h2;

        cyc(1, 0, 3'd3);
        cyc(1, 1, 3'd2);
        lit("reset", 4'h0, 4'hF, 1'b0);

        cyc(0, 1, 3'd0); lit("sweep0", 4'hE, 4'h1, 1'b0);
        cyc(0, 1, 3'd1); lit("sweep1", 4'hF, 4'h0, 1'b0);
        cyc(0, 1, 3'd2); lit("sweep2", 4'h0, 4'hF, 1'b0);
        cyc(0, 1, 3'd3); lit("sweep3", 4'h1, 4'hE, 1'b0);
        cyc(0, 1, 3'd4); lit("sweep4", 4'h2, 4'hD, 1'b0);

        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 3'd0);
            lit("hold", 4'h2, 4'hD, 1'b0);
        end

        cyc(0, 1, 3'd3); lit("pre_oor", 4'h1, 4'hE, 1'b0);
        cyc(0, 1, 3'd6);
        if (OOR_HOLD) lit("oor", 4'h1, 4'hE, 1'b1);
        else          lit("oor", 4'h0, 4'hF, 1'b1);
        cyc(0, 1, 3'd0); lit("post_oor", 4'hE, 4'h1, 1'b0);

        cyc(0, 1, 3'd1); lit("stream", 4'hF, 4'h0, 1'b0);
        cyc(1, 1, 3'd1); lit("mid_rst", 4'h0, 4'hF, 1'b0);
        cyc(0, 1, 3'd1); lit("resume", 4'hF, 4'h0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 5; k++) din[k] = SZE'($urandom);
            cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
